// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, FSM state encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_COL_W     = 32;
  localparam int unsigned AES_NCOL      = 4;
  localparam int unsigned AES_COL_IDX_W = $clog2(AES_NCOL);
  localparam int unsigned AES_BIT_IDX_W = $clog2(AES_STATE_W);
  localparam logic [7:0]  AES_POLY      = 8'h1b;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    BYPASS = 2'd2,
    DONE   = 2'd3
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by 3 (x + 1) in GF(2^8).
  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns transform of one 32-bit column (a0 = top byte).
module mix_single_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  output logic [AES_COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Fixed MixColumns matrix rows applied to the column bytes.
  always_comb begin
    b0 = xtime(a0) ^ mul3(a1) ^ a2        ^ a3;
    b1 = a0        ^ xtime(a1) ^ mul3(a2) ^ a3;
    b2 = a0        ^ a1        ^ xtime(a2) ^ mul3(a3);
    b3 = mul3(a0)  ^ a1        ^ a2        ^ xtime(a3);
  end

  assign col_out = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_columns_iter.sv
// Column-serial AES MixColumns stage: one column per cycle through a shared
// column multiplier, with a per-block bypass for the final round.
module mix_columns_iter
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] data_in,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] data_out
);

  aes_state_e                 state_q, state_d;
  logic [AES_COL_IDX_W-1:0]   col_q, col_d;
  logic [AES_STATE_W-1:0]     data_q, data_d;
  logic                       byp_wait_q, byp_wait_d;
  logic [AES_BIT_IDX_W-1:0]   col_lsb;
  logic [AES_COL_W-1:0]       col_sel;
  logic [AES_COL_W-1:0]       col_mixed;

  // Column c sits at [127-32c -: 32], i.e. its LSB is 32*(3-c).
  assign col_lsb = {~col_q, 5'b0};
  assign col_sel = data_q[col_lsb +: AES_COL_W];

  mix_single_column u_mix (
    .col_in  (col_sel),
    .col_out (col_mixed)
  );

  // State, column counter and state-array registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      data_q     <= '0;
      byp_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      data_q     <= data_d;
      byp_wait_q <= byp_wait_d;
    end
  end

  // Next-state decode; BYPASS dwells two cycles so the bypass latency is 2.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)           state_d = in_bypass ? BYPASS : CALC;
      CALC:    if (col_q == 2'd3)      state_d = DONE;
      BYPASS:  if (byp_wait_q)         state_d = DONE;
      DONE:    if (out_ready)          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Datapath updates: latch on accept, rewrite one column per CALC cycle.
  always_comb begin
    data_d     = data_q;
    col_d      = col_q;
    byp_wait_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = data_in;
          col_d  = '0;
        end
      end
      CALC: begin
        data_d[col_lsb +: AES_COL_W] = col_mixed;
        col_d                        = col_q + 2'd1;
      end
      BYPASS:  byp_wait_d = ~byp_wait_q;
      default: ;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter using FIPS-197 MixColumns vectors.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  int n_pass  = 0;
  int n_total = 0;

  mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block for one edge (the accept edge T); returns at T+1ns.
  task automatic send(input logic [127:0] d, input logic byp);
    chk("ready_before_send", 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    data_in   = d;
    in_bypass = byp;
    tick();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
  endtask

  // Count edges after T until out_valid is seen (bounded).
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid_low", 128'(out_valid), 128'(0));
    chk("hs_in_ready_high", 128'(in_ready), 128'(1));
  endtask

  task automatic run_block(input string tag, input logic [127:0] d, input logic byp,
                           input int exp_lat, input logic [127:0] exp_d);
    int lat;
    send(d, byp);
    chk({tag, "_busy"}, 128'(in_ready), 128'(0));
    wait_out(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_data"}, data_out, exp_d);
    handshake();
  endtask

  initial begin
    int lat;
    int k;
    int first_k;
    int second_k;
    logic [127:0] blk_a;
    logic [127:0] blk_b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    in_bypass = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out", data_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single-column vectors in column 0.
    run_block("col_db", {32'hdb135345, 96'h0}, 1'b0, 4, {32'h8e4da1bc, 96'h0});
    run_block("col_f2", {32'hf20a225c, 96'h0}, 1'b0, 4, {32'h9fdc589d, 96'h0});
    run_block("col_2d", {32'h2d26314c, 96'h0}, 1'b0, 4, {32'h4d7ebdf8, 96'h0});
    run_block("col_d4", {32'hd4d4d4d5, 96'h0}, 1'b0, 4, {32'hd5d5d7d6, 96'h0});

    // Full FIPS-197 round-1 state.
    run_block("full", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 4,
              128'h046681e5e0cb199a48f8d37a2806264c);

    // Bypass passes the block unchanged with a 2-cycle latency.
    run_block("bypass", 128'h00112233445566778899aabbccddeeff, 1'b1, 2,
              128'h00112233445566778899aabbccddeeff);

    // Backpressure: DONE held 10 cycles with a waiting in_valid.
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
    wait_out(lat);
    chk("bp_latency", 128'(lat), 128'(4));
    in_valid = 1'b1;
    data_in  = {32'hdb135345, 96'h0};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_data_stable", data_out, 128'h046681e5e0cb199a48f8d37a2806264c);
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_out_valid", 128'(out_valid), 128'(0));
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_accept_next", 128'(in_ready), 128'(0));
    wait_out(lat);
    chk("bp_next_latency", 128'(lat), 128'(4));
    chk("bp_next_data", data_out, {32'h8e4da1bc, 96'h0});
    handshake();

    // Reset two cycles after accept discards the in-flight block.
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data_out", data_out, 128'h0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_output", 128'(out_valid), 128'(0));
    end
    run_block("post_rst", {32'hf20a225c, 96'h0}, 1'b0, 4, {32'h9fdc589d, 96'h0});

    // Back-to-back idempotent blocks with out_ready tied high.
    blk_a     = {16{8'h01}};
    blk_b     = {16{8'hc6}};
    first_k   = -1;
    second_k  = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = blk_a;
    tick();
    data_in = blk_b;
    for (k = 1; k <= 14; k++) begin
      tick();
      if (k == 6) begin
        chk("b2b_second_accept", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (first_k < 0) begin
          first_k = k;
          chk("b2b_first_data", data_out, blk_a);
        end else if (second_k < 0) begin
          second_k = k;
          chk("b2b_second_data", data_out, blk_b);
        end
      end
    end
    out_ready = 1'b0;
    chk("b2b_first_latency", 128'(first_k), 128'(4));
    chk("b2b_cadence", 128'(second_k - first_k), 128'(6));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
